// File: rtl/pipeline_ctrl.sv
// Pipeline control for the 5-stage 16-bit core: advance/bubble controls for the PC and
// the four pipeline registers, hazard/miss stalls, HLT drain and a saturating stall counter.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             halt_id,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_wren,
    output logic             ifid_wren,
    output logic             ifid_clr,
    output logic             idex_wren,
    output logic             idex_clr,
    output logic             exmem_wren,
    output logic             exmem_clr,
    output logic             memwb_wren,
    output logic             memwb_clr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [1:0] drain_cnt, drain_nxt;
    logic       load_use;

    // R0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_memread && (ex_rd != 4'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        pc_wren    = 1'b1;
        ifid_wren  = 1'b1;
        ifid_clr   = 1'b0;
        idex_wren  = 1'b1;
        idex_clr   = 1'b0;
        exmem_wren = 1'b1;
        exmem_clr  = 1'b0;
        memwb_wren = 1'b1;
        memwb_clr  = 1'b0;
        halted     = 1'b0;

        if (rst) begin
            pc_wren    = 1'b0;
            ifid_wren  = 1'b0;
            idex_wren  = 1'b0;
            exmem_wren = 1'b0;
            memwb_wren = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (dmem_stall) begin
                        pc_wren    = 1'b0;
                        ifid_wren  = 1'b0;
                        idex_wren  = 1'b0;
                        exmem_wren = 1'b0;
                        memwb_clr  = 1'b1;
                    end else if (load_use) begin
                        pc_wren   = 1'b0;
                        ifid_wren = 1'b0;
                        idex_clr  = 1'b1;
                    end else if (halt_id) begin
                        pc_wren   = 1'b0;
                        ifid_clr  = 1'b1;
                        state_nxt = DRAIN;
                        drain_nxt = 2'd3;
                    end else if (branch_taken) begin
                        // A redirect beats an instruction miss: the PC loads the target.
                        ifid_clr = 1'b1;
                    end else if (imem_stall) begin
                        pc_wren  = 1'b0;
                        ifid_clr = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_wren   = 1'b0;
                    ifid_wren = 1'b0;
                    ifid_clr  = 1'b1;
                    if (dmem_stall) begin
                        idex_wren  = 1'b0;
                        exmem_wren = 1'b0;
                        memwb_clr  = 1'b1;
                    end else begin
                        // HLT reaches MEM/WB on the cycle the count leaves 1.
                        drain_nxt = drain_cnt - 2'd1;
                        if (drain_cnt <= 2'd1) begin
                            drain_nxt = 2'd0;
                            state_nxt = HALTED;
                        end
                    end
                end
                HALTED: begin
                    pc_wren    = 1'b0;
                    ifid_wren  = 1'b0;
                    idex_wren  = 1'b0;
                    exmem_wren = 1'b0;
                    memwb_wren = 1'b0;
                    halted     = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if ((state == RUN) && !pc_wren && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the control rules.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_rs, id_rt, ex_rd;
    logic id_uses_rs, id_uses_rt, ex_memread;
    logic branch_taken, halt_id, imem_stall, dmem_stall;
    logic pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr;
    logic exmem_wren, exmem_clr, memwb_wren, memwb_clr, halted;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model state: halted flag, remaining drain cycles, stall count as a plain integer.
    bit m_halted;
    int m_drain_left;
    int m_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .halt_id(halt_id), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_wren(pc_wren), .ifid_wren(ifid_wren), .ifid_clr(ifid_clr),
        .idex_wren(idex_wren), .idex_clr(idex_clr),
        .exmem_wren(exmem_wren), .exmem_clr(exmem_clr),
        .memwb_wren(memwb_wren), .memwb_clr(memwb_clr),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Control vector order: pc, ifid_w, ifid_c, idex_w, idex_c, exmem_w, exmem_c, memwb_w, memwb_c
    logic [8:0] act_ctl;
    assign act_ctl = {pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr,
                      exmem_wren, exmem_clr, memwb_wren, memwb_clr};
    logic [13:0] act_vec;
    assign act_vec = {act_ctl, halted, stall_cnt};

    localparam logic [8:0] CTL_NORMAL = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] CTL_LDUSE  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] CTL_BRANCH = 9'b1_1_1_1_0_1_0_1_0;
    localparam logic [8:0] CTL_DMEM   = 9'b0_0_0_0_0_0_0_1_1;

    function automatic bit is_load_use();
        if (!ex_memread || ex_rd == 4'd0) return 1'b0;
        return (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
    endfunction

    function automatic logic [8:0] exp_ctl();
        bit pc, ifw, ifc, idw, idc, exw, exc, mww, mwc;
        if (rst || m_halted) return 9'd0;
        {pc, ifw, ifc, idw, idc, exw, exc, mww, mwc} = CTL_NORMAL;
        if (m_drain_left > 0) begin
            pc = 0; ifw = 0; ifc = 1;
            if (dmem_stall) begin idw = 0; exw = 0; mwc = 1; end
        end else if (dmem_stall) begin
            pc = 0; ifw = 0; idw = 0; exw = 0; mwc = 1;
        end else if (is_load_use()) begin
            pc = 0; ifw = 0; idc = 1;
        end else if (halt_id) begin
            pc = 0; ifc = 1;
        end else if (branch_taken) begin
            ifc = 1;
        end else if (imem_stall) begin
            pc = 0; ifc = 1;
        end
        return {pc, ifw, ifc, idw, idc, exw, exc, mww, mwc};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [CNT_W-1:0] c;
        c = rst ? '0 : CNT_W'(m_cnt);
        return {exp_ctl(), (m_halted && !rst), c};
    endfunction

    // Advance one clock edge and move the model across the same edge.
    task automatic tick();
        logic [8:0] c;
        @(posedge clk);
        c = exp_ctl();
        if (rst) begin
            m_halted = 0; m_drain_left = 0; m_cnt = 0;
        end else if (m_halted) begin
            // frozen
        end else if (m_drain_left > 0) begin
            if (!dmem_stall) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end else begin
            if (!c[8]) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (!dmem_stall && !is_load_use() && halt_id) m_drain_left = 3;
        end
        #1;
    endtask

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_memread = 0; ex_rd = 0; branch_taken = 0; halt_id = 0;
        imem_stall = 0; dmem_stall = 0;
    endtask

    task automatic do_reset();
        rst = 1; set_idle();
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; set_idle();
        @(negedge clk);
        n_vec++;
        if (act_vec !== 14'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b want %b", act_vec, 14'd0);
        end
        tick();
        rst = 0;
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_NORMAL, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL reset_first_run: got %b want %b", act_vec, {CTL_NORMAL, 1'b0, 4'd0});
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1;
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_LDUSE, 1'b0, 4'd0} || act_vec !== exp_vec()) begin
            n_err++; $display("FAIL load_use_stall: got %b want %b", act_vec, {CTL_LDUSE, 1'b0, 4'd0});
        end
        tick();
        set_idle();
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_NORMAL, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL load_use_after: got %b want %b", act_vec, {CTL_NORMAL, 1'b0, 4'd1});
        end
        tick();
        ex_memread = 1; ex_rd = 4'd0; id_rs = 4'd0; id_uses_rs = 1; id_rt = 4'd0; id_uses_rt = 1;
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_NORMAL, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL load_use_r0: got %b want %b", act_vec, {CTL_NORMAL, 1'b0, 4'd1});
        end
        tick();
        set_idle();
        ex_memread = 1; ex_rd = 4'd7; id_rt = 4'd7; id_uses_rt = 1; id_rs = 4'd7; id_uses_rs = 0;
        @(negedge clk);
        n_vec++;
        if (act_ctl !== CTL_LDUSE) begin
            n_err++; $display("FAIL load_use_rt: got %b want %b", act_ctl, CTL_LDUSE);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch_imem();
        do_reset();
        branch_taken = 1; imem_stall = 1;
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_BRANCH, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL branch_imem: got %b want %b", act_vec, {CTL_BRANCH, 1'b0, 4'd0});
        end
        tick();
        branch_taken = 0;
        @(negedge clk);
        n_vec++;
        if (act_vec !== exp_vec() || stall_cnt !== 4'd0) begin
            n_err++; $display("FAIL imem_only: got %b want %b", act_vec, exp_vec());
        end
        tick();
        set_idle();
    endtask

    task automatic test_dmem_stall();
        do_reset();
        dmem_stall = 1; branch_taken = 1;
        ex_memread = 1; ex_rd = 4'd5; id_rs = 4'd5; id_uses_rs = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (act_vec !== {CTL_DMEM, 1'b0, 4'(i)}) begin
                n_err++; $display("FAIL dmem_stall_%0d: got %b want %b", i, act_vec, {CTL_DMEM, 1'b0, 4'(i)});
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_NORMAL, 1'b0, 4'd4}) begin
            n_err++; $display("FAIL dmem_release: got %b want %b", act_vec, {CTL_NORMAL, 1'b0, 4'd4});
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        imem_stall = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++; $display("FAIL sat_cycle_%0d: got %b want %b", i, act_vec, exp_vec());
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        n_vec++;
        if (stall_cnt !== 4'd15) begin
            n_err++; $display("FAIL sat_final: got %0d want 15", stall_cnt);
        end
        tick();
    endtask

    // Pulse HLT at cycle T; dmem stalls on the first dmem_cycles DRAIN cycles.
    task automatic run_halt(input int dmem_cycles, input int want_delay, input string name);
        int k;
        do_reset();
        halt_id = 1;
        tick();
        halt_id = 0;
        k = 1;
        while (k <= 20) begin
            dmem_stall = (k <= dmem_cycles);
            @(negedge clk);
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++; $display("FAIL %s_cyc%0d: got %b want %b", name, k, act_vec, exp_vec());
            end
            if (halted === 1'b1) break;
            tick();
            k++;
        end
        dmem_stall = 0;
        n_vec++;
        if (k != want_delay) begin
            n_err++; $display("FAIL %s_latency: got T+%0d want T+%0d", name, k, want_delay);
        end
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] cnt_snap;
        run_halt(0, 4, "halt");
        run_halt(2, 6, "halt_dmem");
        cnt_snap = stall_cnt;
        for (int i = 0; i < 8; i++) begin
            {id_rs, id_rt, ex_rd} = 12'($urandom);
            {id_uses_rs, id_uses_rt, ex_memread, branch_taken, halt_id, imem_stall, dmem_stall} = 7'($urandom);
            @(negedge clk);
            n_vec++;
            if (act_vec !== {9'd0, 1'b1, cnt_snap}) begin
                n_err++; $display("FAIL halted_frozen_%0d: got %b want %b", i, act_vec, {9'd0, 1'b1, cnt_snap});
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        imem_stall = 1;
        tick();
        imem_stall = 0;
        halt_id = 1;
        tick();
        halt_id = 0;
        #2 rst = 1;
        @(negedge clk);
        n_vec++;
        if (act_vec !== 14'd0) begin
            n_err++; $display("FAIL drain_reset: got %b want %b", act_vec, 14'd0);
        end
        tick();
        rst = 0;
        @(negedge clk);
        n_vec++;
        if (act_vec !== {CTL_NORMAL, 1'b0, 4'd0}) begin
            n_err++; $display("FAIL drain_reset_release: got %b want %b", act_vec, {CTL_NORMAL, 1'b0, 4'd0});
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            id_rs = 4'($urandom_range(0, 3));
            id_rt = 4'($urandom_range(0, 3));
            ex_rd = 4'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom);
            id_uses_rt = 1'($urandom);
            ex_memread = 1'($urandom);
            branch_taken = 1'($urandom);
            imem_stall = 1'($urandom);
            dmem_stall = ($urandom_range(0, 3) == 0);
            halt_id = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            n_vec++;
            if (act_vec !== exp_vec()) begin
                n_err++; $display("FAIL random_%0d: got %b want %b", i, act_vec, exp_vec());
            end
            tick();
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_halted = 0; m_drain_left = 0; m_cnt = 0;
        rst = 1;
        set_idle();
        #1;
        test_reset();
        test_load_use();
        test_branch_imem();
        test_dmem_stall();
        test_saturation();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
